sram_march_bist_ctrl: RTL and testbench

//   March C- BIST initiator for the 1-port SRAM macros with a BIST port (e.g. 8192x32 c4 bm).

---
 rtl/sram_march_bist_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_sram_march_bist_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/sram_march_bist_ctrl.sv
// March C- BIST initiator for a single-port SRAM macro with a BIST port.
// Issues one op per cycle, compares read-back one cycle after capture, and records the first failure.
module sram_march_bist_ctrl #(
    parameter int                        P_ADDR_WIDTH = 13,
    parameter int                        P_DATA_WIDTH = 32,
    parameter logic [P_DATA_WIDTH-1:0]   P_PATTERN    = {P_DATA_WIDTH{1'b0}}
) (
    input  logic                    A_CLK,
    input  logic                    A_RST_N,
    input  logic                    A_START,
    output logic                    A_BUSY,
    output logic                    A_DONE,
    output logic                    A_FAIL,
    output logic [P_ADDR_WIDTH-1:0] A_FAIL_ADDR,
    output logic [2:0]              A_FAIL_ELEM,
    output logic [P_DATA_WIDTH-1:0] A_FAIL_DATA,
    output logic                    A_BIST_EN,
    output logic                    A_BIST_MEN,
    output logic                    A_BIST_WEN,
    output logic                    A_BIST_REN,
    output logic [P_ADDR_WIDTH-1:0] A_BIST_ADDR,
    output logic [P_DATA_WIDTH-1:0] A_BIST_DIN,
    output logic [P_DATA_WIDTH-1:0] A_BIST_BM,
    input  logic [P_DATA_WIDTH-1:0] A_DOUT
);

    localparam logic [P_ADDR_WIDTH-1:0] ADDR_ZERO = {P_ADDR_WIDTH{1'b0}};
    localparam logic [P_ADDR_WIDTH-1:0] ADDR_MAX  = {P_ADDR_WIDTH{1'b1}};
    localparam logic [P_ADDR_WIDTH-1:0] ADDR_ONE  = {{(P_ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [P_DATA_WIDTH-1:0] DATA_ZERO = {P_DATA_WIDTH{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_FINISH = 2'd3
    } state_t;

    // Background written by each element: M1/M3 write ones, the rest write zeros.
    function automatic logic [P_DATA_WIDTH-1:0] write_bg(input logic [2:0] elem);
        case (elem)
            3'd1, 3'd3: write_bg = ~P_PATTERN;
            default:    write_bg = P_PATTERN;
        endcase
    endfunction

    // Background expected by the read of each element: M2/M4 read ones.
    function automatic logic [P_DATA_WIDTH-1:0] read_bg(input logic [2:0] elem);
        case (elem)
            3'd2, 3'd4: read_bg = ~P_PATTERN;
            default:    read_bg = P_PATTERN;
        endcase
    endfunction

    state_t                    state_r, nxt_state_s;
    logic [2:0]                elem_r, nxt_elem_s;
    logic [P_ADDR_WIDTH-1:0]   addr_r, nxt_addr_s;
    logic                      men_r, wen_r, ren_r;
    logic                      nxt_men_s, nxt_wen_s, nxt_ren_s;
    logic [P_DATA_WIDTH-1:0]   din_r, nxt_din_s;
    logic                      busy_r, nxt_busy_s, done_r, nxt_done_s;
    logic                      fail_r;
    logic [P_ADDR_WIDTH-1:0]   fail_addr_r;
    logic [2:0]                fail_elem_r;
    logic [P_DATA_WIDTH-1:0]   fail_data_r;
    logic                      pend_vld_r;
    logic [P_DATA_WIDTH-1:0]   pend_exp_r;
    logic [P_ADDR_WIDTH-1:0]   pend_addr_r;
    logic [2:0]                pend_elem_r;
    logic                      clear_s, capture_s, mismatch_s, down_s, last_in_elem_s;

    assign mismatch_s     = pend_vld_r && !fail_r && (A_DOUT != pend_exp_r);
    assign down_s         = (elem_r == 3'd3) || (elem_r == 3'd4);
    assign last_in_elem_s = down_s ? (addr_r == ADDR_ZERO) : (addr_r == ADDR_MAX);

    // Next-state, next-op sequencing and error-capture decisions.
    always_comb begin
        nxt_state_s = state_r;
        nxt_elem_s  = elem_r;
        nxt_addr_s  = addr_r;
        nxt_men_s   = 1'b0;
        nxt_wen_s   = 1'b0;
        nxt_ren_s   = 1'b0;
        nxt_busy_s  = busy_r;
        nxt_done_s  = done_r;
        clear_s     = 1'b0;
        capture_s   = 1'b0;
        case (state_r)
            ST_IDLE, ST_FINISH: begin
                if (A_START) begin
                    nxt_state_s = ST_RUN;
                    nxt_elem_s  = 3'd0;
                    nxt_addr_s  = ADDR_ZERO;
                    nxt_men_s   = 1'b1;
                    nxt_wen_s   = 1'b1;
                    nxt_busy_s  = 1'b1;
                    nxt_done_s  = 1'b0;
                    clear_s     = 1'b1;
                end else begin
                    nxt_state_s = state_r;
                end
            end
            ST_RUN: begin
                if (mismatch_s) begin
                    capture_s   = 1'b1;
                    nxt_state_s = ST_DRAIN;
                end else if ((elem_r == 3'd5) && (addr_r == ADDR_MAX)) begin
                    nxt_state_s = ST_DRAIN;
                end else begin
                    nxt_men_s = 1'b1;
                    if (elem_r == 3'd0) begin
                        if (addr_r == ADDR_MAX) begin
                            nxt_elem_s = 3'd1;
                            nxt_addr_s = ADDR_ZERO;
                            nxt_ren_s  = 1'b1;
                        end else begin
                            nxt_addr_s = addr_r + ADDR_ONE;
                            nxt_wen_s  = 1'b1;
                        end
                    end else if (elem_r == 3'd5) begin
                        nxt_addr_s = addr_r + ADDR_ONE;
                        nxt_ren_s  = 1'b1;
                    end else if (ren_r) begin
                        nxt_wen_s = 1'b1;
                    end else if (last_in_elem_s) begin
                        // M3 and M4 start from the top address; M2 and M5 from zero.
                        nxt_elem_s = elem_r + 3'd1;
                        nxt_addr_s = ((elem_r == 3'd2) || (elem_r == 3'd3)) ? ADDR_MAX : ADDR_ZERO;
                        nxt_ren_s  = 1'b1;
                    end else begin
                        nxt_addr_s = down_s ? (addr_r - ADDR_ONE) : (addr_r + ADDR_ONE);
                        nxt_ren_s  = 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                nxt_state_s = ST_FINISH;
                nxt_busy_s  = 1'b0;
                nxt_done_s  = 1'b1;
                capture_s   = mismatch_s;
            end
            default: begin
                nxt_state_s = ST_IDLE;
                nxt_busy_s  = 1'b0;
                nxt_done_s  = 1'b0;
            end
        endcase
        nxt_din_s = nxt_wen_s ? write_bg(nxt_elem_s) : DATA_ZERO;
    end

    // State, op outputs, compare pipeline and first-failure capture.
    always_ff @(posedge A_CLK) begin
        if (!A_RST_N) begin
            state_r     <= ST_IDLE;
            elem_r      <= 3'd0;
            addr_r      <= ADDR_ZERO;
            men_r       <= 1'b0;
            wen_r       <= 1'b0;
            ren_r       <= 1'b0;
            din_r       <= DATA_ZERO;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            fail_r      <= 1'b0;
            fail_addr_r <= ADDR_ZERO;
            fail_elem_r <= 3'd0;
            fail_data_r <= DATA_ZERO;
            pend_vld_r  <= 1'b0;
            pend_exp_r  <= DATA_ZERO;
            pend_addr_r <= ADDR_ZERO;
            pend_elem_r <= 3'd0;
        end else begin
            state_r     <= nxt_state_s;
            elem_r      <= nxt_elem_s;
            addr_r      <= nxt_addr_s;
            men_r       <= nxt_men_s;
            wen_r       <= nxt_wen_s;
            ren_r       <= nxt_ren_s;
            din_r       <= nxt_din_s;
            busy_r      <= nxt_busy_s;
            done_r      <= nxt_done_s;
            pend_vld_r  <= ren_r;
            pend_exp_r  <= read_bg(elem_r);
            pend_addr_r <= addr_r;
            pend_elem_r <= elem_r;
            if (clear_s) begin
                fail_r      <= 1'b0;
                fail_addr_r <= ADDR_ZERO;
                fail_elem_r <= 3'd0;
                fail_data_r <= DATA_ZERO;
            end else if (capture_s) begin
                fail_r      <= 1'b1;
                fail_addr_r <= pend_addr_r;
                fail_elem_r <= pend_elem_r;
                fail_data_r <= A_DOUT;
            end else begin
                fail_r      <= fail_r;
            end
        end
    end

    assign A_BUSY      = busy_r;
    assign A_BIST_EN   = busy_r;
    assign A_DONE      = done_r;
    assign A_FAIL      = fail_r;
    assign A_FAIL_ADDR = fail_addr_r;
    assign A_FAIL_ELEM = fail_elem_r;
    assign A_FAIL_DATA = fail_data_r;
    assign A_BIST_MEN  = men_r;
    assign A_BIST_WEN  = wen_r;
    assign A_BIST_REN  = ren_r;
    assign A_BIST_ADDR = addr_r;
    assign A_BIST_DIN  = din_r;
    assign A_BIST_BM   = {P_DATA_WIDTH{men_r}};

endmodule

// File: tb/tb_sram_march_bist_ctrl.sv
// Bench for sram_march_bist_ctrl: behavioural faulty SRAM behind the BIST port and a
// March C- reference built from the element table, predicting the op trace and first failure.
module tb_sram_march_bist_ctrl;

    localparam int          AW  = 3;
    localparam int          DW  = 8;
    localparam int          N   = 8;
    localparam logic [7:0]  PAT = 8'h00;

    logic           A_CLK, A_RST_N, A_START;
    logic           A_BUSY, A_DONE, A_FAIL;
    logic [AW-1:0]  A_FAIL_ADDR;
    logic [2:0]     A_FAIL_ELEM;
    logic [DW-1:0]  A_FAIL_DATA;
    logic           A_BIST_EN, A_BIST_MEN, A_BIST_WEN, A_BIST_REN;
    logic [AW-1:0]  A_BIST_ADDR;
    logic [DW-1:0]  A_BIST_DIN, A_BIST_BM, A_DOUT;

    int n_checks = 0;
    int n_fail   = 0;

    sram_march_bist_ctrl #(
        .P_ADDR_WIDTH(AW), .P_DATA_WIDTH(DW), .P_PATTERN(PAT)
    ) dut (
        .A_CLK(A_CLK), .A_RST_N(A_RST_N), .A_START(A_START),
        .A_BUSY(A_BUSY), .A_DONE(A_DONE), .A_FAIL(A_FAIL),
        .A_FAIL_ADDR(A_FAIL_ADDR), .A_FAIL_ELEM(A_FAIL_ELEM), .A_FAIL_DATA(A_FAIL_DATA),
        .A_BIST_EN(A_BIST_EN), .A_BIST_MEN(A_BIST_MEN), .A_BIST_WEN(A_BIST_WEN),
        .A_BIST_REN(A_BIST_REN), .A_BIST_ADDR(A_BIST_ADDR), .A_BIST_DIN(A_BIST_DIN),
        .A_BIST_BM(A_BIST_BM), .A_DOUT(A_DOUT)
    );

    initial A_CLK = 1'b0;
    always #5 A_CLK = ~A_CLK;

    // Behavioural SRAM with per-word stuck-at masks applied on read.
    logic [7:0] mem [N];
    logic [7:0] sa1 [N];
    logic [7:0] sa0 [N];
    always @(posedge A_CLK) begin
        if (A_BIST_EN && A_BIST_MEN && A_BIST_WEN)
            mem[A_BIST_ADDR] <= (mem[A_BIST_ADDR] & ~A_BIST_BM) | (A_BIST_DIN & A_BIST_BM);
        if (A_BIST_EN && A_BIST_MEN && A_BIST_REN)
            A_DOUT <= (mem[A_BIST_ADDR] | sa1[A_BIST_ADDR]) & ~sa0[A_BIST_ADDR];
    end

    typedef struct {
        bit         wr;
        int         addr;
        logic [7:0] data;
        int         elem;
    } op_t;
    op_t ops[$];

    task automatic push_op(input bit wr, input int a, input logic [7:0] d, input int el);
        op_t o;
        o.wr = wr; o.addr = a; o.data = d; o.elem = el;
        ops.push_back(o);
    endtask

    task automatic build_march();
        ops.delete();
        for (int a = 0; a < N; a++) push_op(1'b1, a, PAT, 0);
        for (int a = 0; a < N; a++) begin push_op(1'b0, a, PAT, 1);  push_op(1'b1, a, ~PAT, 1); end
        for (int a = 0; a < N; a++) begin push_op(1'b0, a, ~PAT, 2); push_op(1'b1, a, PAT, 2);  end
        for (int a = N-1; a >= 0; a--) begin push_op(1'b0, a, PAT, 3);  push_op(1'b1, a, ~PAT, 3); end
        for (int a = N-1; a >= 0; a--) begin push_op(1'b0, a, ~PAT, 4); push_op(1'b1, a, PAT, 4);  end
        for (int a = 0; a < N; a++) push_op(1'b0, a, PAT, 5);
    endtask

    // Walks the op list over a faulty memory; k = index of first failing read or -1.
    task automatic predict(output int k, output int fa, output int fe, output logic [7:0] fd);
        logic [7:0] rm [N];
        logic [7:0] v;
        k = -1; fa = 0; fe = 0; fd = 8'h00;
        for (int i = 0; i < ops.size(); i++) begin
            if (ops[i].wr) begin
                rm[ops[i].addr] = ops[i].data;
            end else begin
                v = (rm[ops[i].addr] | sa1[ops[i].addr]) & ~sa0[ops[i].addr];
                if (v !== ops[i].data) begin
                    k = i; fa = ops[i].addr; fe = ops[i].elem; fd = v;
                    break;
                end
            end
        end
    endtask

    task automatic clear_faults();
        for (int a = 0; a < N; a++) begin sa1[a] = 8'h00; sa0[a] = 8'h00; end
    endtask

    // One complete test from START to DONE, checking trace, timing and result registers.
    task automatic run_march(input string name, input bit hold_start, input int pulse_at);
        int k, fa, fe, e, ops_seen, trace_err, done_edge, exp_ops, exp_done;
        logic [7:0] fd;
        build_march();
        predict(k, fa, fe, fd);
        exp_ops  = (k < 0) ? 80 : ((k + 2 < 80) ? k + 2 : 80);
        exp_done = (k < 0) ? 81 : ((k + 3 < 81) ? k + 3 : 81);
        @(negedge A_CLK);
        A_START = 1'b1;
        e = -1; ops_seen = 0; trace_err = 0; done_edge = -1;
        while (done_edge < 0 && e < 300) begin
            @(posedge A_CLK);
            e++;
            @(negedge A_CLK);
            if (!hold_start) A_START = (e + 1 == pulse_at);
            if (A_BIST_WEN && A_BIST_REN) trace_err++;
            if (A_BIST_EN !== A_BUSY) trace_err++;
            if (A_BIST_MEN) begin
                if (ops_seen >= ops.size()) trace_err++;
                else if (A_BIST_BM !== 8'hFF || A_BIST_WEN !== ops[ops_seen].wr ||
                         A_BIST_REN !== !ops[ops_seen].wr ||
                         A_BIST_ADDR !== 3'(ops[ops_seen].addr) ||
                         (ops[ops_seen].wr && A_BIST_DIN !== ops[ops_seen].data)) trace_err++;
                else trace_err = trace_err;
                ops_seen++;
            end else if (A_BIST_WEN || A_BIST_REN || A_BIST_BM !== 8'h00) begin
                trace_err++;
            end
            if (A_DONE === 1'b1) done_edge = e;
        end
        A_START = 1'b0;
        n_checks++; if (done_edge !== exp_done) begin n_fail++; $display("FAIL %s done_edge: got %0d want %0d", name, done_edge, exp_done); end
        n_checks++; if (ops_seen !== exp_ops) begin n_fail++; $display("FAIL %s op_count: got %0d want %0d", name, ops_seen, exp_ops); end
        n_checks++; if (trace_err !== 0) begin n_fail++; $display("FAIL %s op_trace: got %0d bad cycles want 0", name, trace_err); end
        n_checks++; if (A_FAIL !== (k >= 0)) begin n_fail++; $display("FAIL %s fail_flag: got %b want %b", name, A_FAIL, (k >= 0)); end
        n_checks++; if (A_FAIL_ADDR !== 3'(fa)) begin n_fail++; $display("FAIL %s fail_addr: got %0d want %0d", name, A_FAIL_ADDR, fa); end
        n_checks++; if (A_FAIL_ELEM !== 3'(fe)) begin n_fail++; $display("FAIL %s fail_elem: got %0d want %0d", name, A_FAIL_ELEM, fe); end
        n_checks++; if (A_FAIL_DATA !== fd) begin n_fail++; $display("FAIL %s fail_data: got %h want %h", name, A_FAIL_DATA, fd); end
        repeat (3) @(negedge A_CLK);
        n_checks++; if ({A_DONE, A_BUSY, A_BIST_MEN} !== 3'b100) begin n_fail++; $display("FAIL %s done_hold: got done/busy/men=%b want 100", name, {A_DONE, A_BUSY, A_BIST_MEN}); end
    endtask

    task automatic check_all_zero(input string name);
        n_checks++;
        if ({A_BUSY, A_DONE, A_FAIL, A_FAIL_ADDR, A_FAIL_ELEM, A_FAIL_DATA, A_BIST_EN,
             A_BIST_MEN, A_BIST_WEN, A_BIST_REN, A_BIST_ADDR, A_BIST_DIN, A_BIST_BM} !== 48'h0) begin
            n_fail++;
            $display("FAIL %s outputs_zero: got busy=%b done=%b fail=%b men=%b addr=%0d bm=%h want all 0",
                     name, A_BUSY, A_DONE, A_FAIL, A_BIST_MEN, A_BIST_ADDR, A_BIST_BM);
        end
    endtask

    task automatic test_reset();
        A_RST_N = 1'b0; A_START = 1'b0;
        repeat (3) @(posedge A_CLK);
        @(negedge A_CLK);
        check_all_zero("reset");
        A_RST_N = 1'b1;
    endtask

    task automatic test_good_pass();
        clear_faults();
        run_march("good", 1'b0, 0);
    endtask

    task automatic test_stuck_faults();
        clear_faults(); sa1[5] = 8'h01;
        run_march("sa1_a5_b0", 1'b0, 0);
        clear_faults(); sa0[2] = 8'h80;
        run_march("sa0_a2_b7", 1'b0, 0);
        clear_faults();
    endtask

    task automatic test_reset_mid_test();
        clear_faults();
        @(negedge A_CLK); A_START = 1'b1;
        @(negedge A_CLK); A_START = 1'b0;
        repeat (39) @(negedge A_CLK);
        A_RST_N = 1'b0;
        @(negedge A_CLK);
        check_all_zero("reset_mid");
        A_RST_N = 1'b1;
        repeat (90) @(negedge A_CLK);
        n_checks++; if ({A_DONE, A_BUSY} !== 2'b00) begin n_fail++; $display("FAIL reset_mid abandoned: got done/busy=%b want 00", {A_DONE, A_BUSY}); end
        run_march("after_reset", 1'b0, 0);
    endtask

    task automatic test_start_control();
        clear_faults();
        run_march("start_held", 1'b1, 0);
        run_march("start_pulse_in_run", 1'b0, 30);
    endtask

    task automatic test_random_faults();
        int a, b, n;
        for (int t = 0; t < 6; t++) begin
            clear_faults();
            n = $urandom_range(1, 2);
            for (int j = 0; j < n; j++) begin
                a = $urandom_range(0, N-1);
                b = $urandom_range(0, 7);
                if ($urandom_range(0, 1) == 0) sa0[a] = sa0[a] | (8'h01 << b);
                else sa1[a] = sa1[a] | (8'h01 << b);
            end
            repeat ($urandom_range(0, 5)) @(negedge A_CLK);
            run_march($sformatf("random%0d", t), 1'b0, $urandom_range(0, 1) == 0 ? 0 : $urandom_range(2, 70));
        end
        clear_faults();
    endtask

    task automatic test_back_to_back();
        clear_faults();
        run_march("b2b_first", 1'b0, 0);
        run_march("b2b_second", 1'b0, 0);
    endtask

    initial begin
        A_RST_N = 1'b0; A_START = 1'b0;
        clear_faults();
        test_reset();
        test_good_pass();
        test_stuck_faults();
        test_reset_mid_test();
        test_start_control();
        test_random_faults();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
